// File: rtl/change_dispenser.sv
// Pays out a change amount one coin per handshake, largest denomination first (50/10/5/1).
// All outputs registered; an unacknowledged coin past TIMEOUT_CYC cycles locks into a sticky fault.
module change_dispenser #(
   parameter int AMT_W       = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             change_valid,
   input  logic [AMT_W-1:0] change_amt,
   output logic [3:0]       coin_out,
   output logic             coin_out_valid,
   input  logic             coin_out_ack,
   output logic [AMT_W-1:0] remaining,
   output logic             busy,
   output logic             done,
   output logic             fault
);

   localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   localparam logic [AMT_W-1:0] D50 = AMT_W'(50);
   localparam logic [AMT_W-1:0] D10 = AMT_W'(10);
   localparam logic [AMT_W-1:0] D5  = AMT_W'(5);
   localparam logic [AMT_W-1:0] D1  = AMT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      ISSUE,
      DONE,
      FAULT
   } state_t;

   state_t           state_q;
   logic [3:0]       coin_q;
   logic             vld_q;
   logic [AMT_W-1:0] rem_q;
   logic             busy_q;
   logic             done_q;
   logic             fault_q;
   logic [CNT_W-1:0] cnt_q;

   logic [3:0]       coin_d;
   logic [AMT_W-1:0] coin_val;
   logic [AMT_W-1:0] rem_d;

   // Largest coin that still fits in what is owed.
   always_comb begin
      coin_d = 4'b0001;
      if (rem_q >= D50) begin
         coin_d = 4'b1000;
      end else if (rem_q >= D10) begin
         coin_d = 4'b0100;
      end else if (rem_q >= D5) begin
         coin_d = 4'b0010;
      end
   end

   always_comb begin
      coin_val = '0;
      case (coin_q)
         4'b1000: coin_val = D50;
         4'b0100: coin_val = D10;
         4'b0010: coin_val = D5;
         4'b0001: coin_val = D1;
         default: coin_val = '0;
      endcase
      rem_d = rem_q - coin_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         coin_q  <= '0;
         vld_q   <= 1'b0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (change_valid) begin
                  rem_q  <= change_amt;
                  busy_q <= 1'b1;
                  if (change_amt == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SELECT;
                  end
               end
            end
            SELECT: begin
               coin_q  <= coin_d;
               vld_q   <= 1'b1;
               cnt_q   <= '0;
               state_q <= ISSUE;
            end
            ISSUE: begin
               // An ack on the timeout edge still counts as a successful dispense.
               if (coin_out_ack) begin
                  vld_q  <= 1'b0;
                  coin_q <= '0;
                  rem_q  <= rem_d;
                  if (rem_d == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SELECT;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  vld_q   <= 1'b0;
                  coin_q  <= '0;
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               rem_q   <= '0;
               state_q <= IDLE;
            end
            FAULT: begin
               state_q <= FAULT;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign coin_out       = coin_q;
   assign coin_out_valid = vld_q;
   assign remaining      = rem_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign fault          = fault_q;

endmodule
